vram_arbiter: RTL

- Shares the single-port 8 KB VRAM between three requesters: LCD pixel fetch, CPU bus, and the VRAM DMA write engine.
- Issues one RAM access per clock and returns read data one cycle later, because the RAM has synchronous read.
- LCD fetch has absolute priority and bounded latency. CPU and DMA share the remaining slots round-robin.
- Sits between the LCD scan block (which provides a VRAM byte address) and the VRAM macro.

---
 rtl/vram_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// VRAM arbiter: one access per clock among LCD fetch (absolute priority), CPU and DMA (round-robin).
// Two-stage pipeline: issue drives the RAM combinationally, complete uses the registered owner tag.
module vram_arbiter #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              lcd_req,
   input  logic [ADDR_W-1:0] lcd_addr,
   output logic [DATA_W-1:0] lcd_data,
   output logic              lcd_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              lcd_overrun,
   input  logic              overrun_clr
);

   // owner tag | meaning
   // OWN_NONE  | no access issued / completing
   // OWN_LCD   | LCD fetch in flight
   // OWN_CPU   | CPU read or write in flight
   // OWN_DMA   | DMA write in flight
   typedef enum logic [1:0] {OWN_NONE, OWN_LCD, OWN_CPU, OWN_DMA} owner_t;

   owner_t            r_tag;
   owner_t            w_win;
   logic              r_lcd_pend;
   logic [ADDR_W-1:0] r_lcd_paddr;
   logic [ADDR_W-1:0] r_last_addr;
   logic              r_rr_dma;
   logic              r_s1_rd;
   logic [DATA_W-1:0] r_lcd_data;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic              r_overrun;
   logic              w_lcd_issue;
   logic              w_cpu_el;
   logic              w_dma_el;

   // Gating with reset_n makes ram_we drop asynchronously while reset is held.
   assign w_lcd_issue = r_lcd_pend & reset_n;
   assign w_cpu_el    = cpu_req & reset_n & (r_tag != OWN_CPU);
   assign w_dma_el    = dma_req & reset_n & (r_tag != OWN_DMA);

   always_comb begin
      w_win     = OWN_NONE;
      ram_addr  = r_last_addr;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (w_lcd_issue)
         w_win = OWN_LCD;
      else if (w_cpu_el && w_dma_el)
         w_win = r_rr_dma ? OWN_DMA : OWN_CPU;
      else if (w_cpu_el)
         w_win = OWN_CPU;
      else if (w_dma_el)
         w_win = OWN_DMA;
      case (w_win)
         OWN_LCD: ram_addr = r_lcd_paddr;
         OWN_CPU: begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
         end
         OWN_DMA: begin
            ram_addr  = dma_addr;
            ram_we    = 1'b1;
            ram_wdata = dma_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tag       <= OWN_NONE;
         r_lcd_pend  <= 1'b0;
         r_lcd_paddr <= '0;
         r_last_addr <= '0;
         r_rr_dma    <= 1'b0;
         r_s1_rd     <= 1'b0;
         r_lcd_data  <= '0;
         r_cpu_rdata <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_tag   <= w_win;
         r_s1_rd <= (w_win == OWN_CPU) && !cpu_we;
         if (w_win != OWN_NONE)
            r_last_addr <= ram_addr;
         if (w_win == OWN_CPU)
            r_rr_dma <= 1'b1;
         else if (w_win == OWN_DMA)
            r_rr_dma <= 1'b0;
         if (lcd_req) begin
            r_lcd_pend  <= 1'b1;
            r_lcd_paddr <= lcd_addr;
         end else if (w_lcd_issue) begin
            r_lcd_pend <= 1'b0;
         end
         // A new collision wins over a simultaneous clear.
         if (lcd_req && r_lcd_pend && !w_lcd_issue)
            r_overrun <= 1'b1;
         else if (overrun_clr)
            r_overrun <= 1'b0;
         if (r_tag == OWN_LCD)
            r_lcd_data <= ram_rdata;
         if (r_tag == OWN_CPU && r_s1_rd)
            r_cpu_rdata <= ram_rdata;
      end
   end

   assign lcd_valid   = (r_tag == OWN_LCD);
   assign cpu_ack     = (r_tag == OWN_CPU);
   assign dma_ack     = (r_tag == OWN_DMA);
   assign lcd_data    = lcd_valid ? ram_rdata : r_lcd_data;
   assign cpu_rdata   = (cpu_ack && r_s1_rd) ? ram_rdata : r_cpu_rdata;
   assign lcd_overrun = r_overrun;

endmodule
